nibble_serial_add_sub: RTL and testbench
========================================

# nibble_serial_add_sub

Multi-cycle WIDTH-bit adder/subtractor that accepts a full-width operand pair and processes it one 4-bit nibble per clock, rippling the carry between nibbles through a carry register. It is the operand-sequencing stage around the team's 4-bit add/sub datapath: it slices wide operands into nibbles on the way in and assembles the wide result and carry on the way out. Valid/ready handshakes on both sides let it sit between an operand producer and a result consumer.

## Interface
- WIDTH, 8: operand and result width; must be a multiple of 4 and at least 4. NIB = WIDTH/4 nibble steps.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- inValid  in  1  operand pair and sub are valid
- inReady  out  1  block can accept operands
- a  in  WIDTH  operand A; bit 0 is the LSB
- b  in  WIDTH  operand B; bit 0 is the LSB
- sub  in  1  0 selects a+b; 1 selects a-b
- outValid  out  1  result is valid
- outReady  in  1  consumer accepts the result
- s  out  WIDTH  sum or difference, modulo 2^WIDTH
- cOut  out  1  carry out of the MSB; for subtraction, 1 means no borrow (a >= b unsigned)
- ovf  out  1  signed overflow; present only with ADD_SUB_OVF_EN

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - inReady=1.
  - On inValid&&inReady: latch a, latch b^{WIDTH{sub}}, latch sub.
  - Carry register ← sub; nibble index ← 0; state → CALC.
- CALC, each cycle:
  - Nibble [4*idx+3 : 4*idx] = aNib + bNib + carry.
  - Write that nibble into the result register; carry ← nibble carry-out; idx++.
  - When idx = NIB-1 is processed: cOut ← final carry; state → DONE.
- DONE:
  - outValid=1; s and cOut held stable.
  - On outReady: state → IDLE.
- inReady is 0 in CALC and in DONE. There is no overlap of operations.
- s and cOut keep the last result after the handshake, until the next operation's DONE.
- Arithmetic:
  - Subtraction is a + ~b + 1.
  - All widths are unsigned modulo 2^WIDTH; cOut is the extra bit.
- Reset, including mid-CALC or mid-DONE:
  - State → IDLE; the in-flight result is discarded.
  - Next cycle: s=0, cOut=0, ovf=0, outValid=0.
  - inReady is 0 while rst is high and 1 on the first cycle after release.

## Timing
- Values after reset: state IDLE, s=0, cOut=0, ovf=0, outValid=0, inReady=0 (while rst=1).
- Latency: accept at edge E0; outValid is high after edge E0+NIB (2 cycles for WIDTH=8).
- Throughput: one operation per NIB+2 cycles when outReady is held high.
- Simultaneous events:
  - inValid in DONE is ignored.
  - An outReady/outValid handshake and new operands are never accepted on the same edge; the new accept happens in IDLE, on the following edge.
- inReady and outValid are decoded combinationally from registered state; there is no combinational path from input ports to output ports.

## Configuration
- ADD_SUB_OVF_EN defined:
  - Adds port ovf.
  - On the final CALC cycle, ovf ← (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - ovf is held with s and cOut.
- ADD_SUB_OVF_EN undefined:
  - No ovf port and no MSB-carry tap.
  - All other behaviour is identical.

## Structure
- Package add_sub_pkg holds:
  - state typedef (IDLE, CALC, DONE);
  - constant NIBBLE_W=4;
  - function for the nibble count from WIDTH.
- Sub-module nibble_adder:
  - combinational 4-bit a+b+cIn → s[3:0], cOut;
  - also outputs c3, the carry into bit 3, used for ovf;
  - one instance, driven by the nibble selected by idx.

## Test plan
- WIDTH=8, 8'h35+8'h4A, sub=0 → s=8'h7F, cOut=0, ovf=0; outValid high exactly 2 cycles after accept.
- WIDTH=8, 8'h0F+8'h01 → s=8'h10 (carry crosses the nibble boundary); 8'hFF+8'h01 → s=8'h00, cOut=1, ovf=0; 8'h7F+8'h01 → s=8'h80, ovf=1.
- WIDTH=8, sub=1:
  - 8'h50-8'h20 → s=8'h30, cOut=1;
  - 8'h10-8'h20 → s=8'hF0, cOut=0, ovf=0;
  - 8'h80-8'h01 → s=8'h7F, cOut=1, ovf=1.
- Backpressure: hold outReady=0 for 5 cycles in DONE while driving inValid=1 → outValid and s stay stable, inReady=0, no accept. Then raise outReady → IDLE next cycle, and the operands are accepted one edge later.
- Reset mid-CALC: assert rst for one cycle during the first nibble → next cycle outValid=0, s=0, cOut=0; inReady=1 after release; a fresh 8'h01+8'h01 gives s=8'h02.
- WIDTH=16, 16'hFFFF+16'h0001 → s=16'h0000, cOut=1, latency 4 cycles. Back-to-back operations with outReady=1 → one result every 6 cycles.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package add_sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit a+b+c_in slice; c3 (carry into bit 3) exists only with ADD_SUB_OVF_EN.
module nibble_adder
  import add_sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] s,
  output logic                c_out
`ifdef ADD_SUB_OVF_EN
  ,
  output logic                c3
`endif
);

  logic [NIBBLE_W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, c_in};
  assign s     = total[NIBBLE_W-1:0];
  assign c_out = total[NIBBLE_W];

`ifdef ADD_SUB_OVF_EN
  logic [NIBBLE_W-1:0] low;

  // Sum of the lower three bits; its top bit is the carry entering bit 3.
  assign low = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b[NIBBLE_W-2:0]}
             + {{(NIBBLE_W-1){1'b0}}, c_in};
  assign c3  = low[NIBBLE_W-1];
`endif

endmodule

// File: rtl/nibble_serial_add_sub.sv
// WIDTH-bit add/sub computed one nibble per clock with valid/ready on both sides.
// Define ADD_SUB_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] s,
  output logic             cOut
`ifdef ADD_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = nibble_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
    $error("nibble_serial_add_sub: WIDTH must be a positive multiple of 4");
  end

  state_t             state, state_next;
  logic               rst_held;
  logic               accept;
  logic               last_nib;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [WIDTH-1:0]   res_reg, res_next;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [NIBBLE_W-1:0] a_nib, b_nib, nib_sum;
  logic               nib_cout;
`ifdef ADD_SUB_OVF_EN
  logic               nib_c3;
`endif

  // rst_held keeps inReady low through reset without a path from the rst pin.
  always_ff @(posedge clk) begin
    rst_held <= rst;
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign last_nib = (idx == IDX_W'(NIB - 1));
  assign accept   = inValid && inReady;

  always_comb begin
    state_next = state;
    inReady    = 1'b0;
    outValid   = 1'b0;
    case (state)
      IDLE: begin
        inReady = !rst_held;
        if (inValid && !rst_held) state_next = CALC;
      end
      CALC: begin
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        outValid = 1'b1;
        if (outReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign a_nib = a_reg[NIBBLE_W*int'(idx) +: NIBBLE_W];
  assign b_nib = b_reg[NIBBLE_W*int'(idx) +: NIBBLE_W];

  nibble_adder u_nibble_adder (
    .a    (a_nib),
    .b    (b_nib),
    .c_in (carry),
    .s    (nib_sum),
    .c_out(nib_cout)
`ifdef ADD_SUB_OVF_EN
    ,
    .c3   (nib_c3)
`endif
  );

  always_comb begin
    res_next = res_reg;
    res_next[NIBBLE_W*int'(idx) +: NIBBLE_W] = nib_sum;
  end

  // Partial results build up in res_reg so s keeps the previous answer until this one completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      s       <= '0;
      cOut    <= 1'b0;
`ifdef ADD_SUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b ^ {WIDTH{sub}};
      carry <= sub;
      idx   <= '0;
    end else if (state == CALC) begin
      res_reg <= res_next;
      carry   <= nib_cout;
      if (last_nib) begin
        s    <= res_next;
        cOut <= nib_cout;
`ifdef ADD_SUB_OVF_EN
        ovf  <= nib_c3 ^ nib_cout;
`endif
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_sub.sv
// Randomised and directed bench for nibble_serial_add_sub at WIDTH=8 and WIDTH=16.
module tb_nibble_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic inValid8, inReady8, sub8, outValid8, outReady8, cOut8;
  logic [7:0] a8, b8, s8;
  logic inValid16, inReady16, sub16, outValid16, outReady16, cOut16;
  logic [15:0] a16, b16, s16;
`ifdef ADD_SUB_OVF_EN
  logic ovf8, ovf16;
`endif

  int checks = 0;
  int errors = 0;

  nibble_serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .inValid(inValid8), .inReady(inReady8),
    .a(a8), .b(b8), .sub(sub8), .outValid(outValid8), .outReady(outReady8),
    .s(s8), .cOut(cOut8)
`ifdef ADD_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  nibble_serial_add_sub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .inValid(inValid16), .inReady(inReady16),
    .a(a16), .b(b16), .sub(sub16), .outValid(outValid16), .outReady(outReady16),
    .s(s16), .cOut(cOut16)
`ifdef ADD_SUB_OVF_EN
    , .ovf(ovf16)
`endif
  );

  // Reference: plain integer arithmetic; returns {ovf, cOut, s}.
  function automatic logic [17:0] ref_model(input int w, input logic [15:0] av,
                                            input logic [15:0] bv, input logic subv);
    longint ua, ub, mask, r, half, sa, sb, exact;
    logic [15:0] sv;
    logic cv, ov;
    mask  = (longint'(1) << w) - 1;
    half  = longint'(1) << (w - 1);
    ua    = longint'(av) & mask;
    ub    = longint'(bv) & mask;
    r     = subv ? (ua + ((~ub) & mask) + 1) : (ua + ub);
    sv    = 16'(r & mask);
    cv    = ((r >> w) & 1) != 0;
    sa    = (ua >= half) ? ua - (mask + 1) : ua;
    sb    = (ub >= half) ? ub - (mask + 1) : ub;
    exact = subv ? (sa - sb) : (sa + sb);
    ov    = (exact >= half) || (exact < -half);
    return {ov, cv, sv};
  endfunction

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic subv,
                     output logic rdy, output int lat, output logic [7:0] so,
                     output logic co, output logic ov);
    @(negedge clk);
    rdy = inReady8;
    a8 = av; b8 = bv; sub8 = subv; inValid8 = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    inValid8 = 1'b0;
    while (outValid8 !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    so = s8; co = cOut8;
`ifdef ADD_SUB_OVF_EN
    ov = ovf8;
`else
    ov = 1'b0;
`endif
    outReady8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady8 = 1'b0;
  endtask

  task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic subv,
                      output logic rdy, output int lat, output logic [15:0] so,
                      output logic co, output logic ov);
    @(negedge clk);
    rdy = inReady16;
    a16 = av; b16 = bv; sub16 = subv; inValid16 = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    inValid16 = 1'b0;
    while (outValid16 !== 1'b1 && lat < 30) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    so = s16; co = cOut16;
`ifdef ADD_SUB_OVF_EN
    ov = ovf16;
`else
    ov = 1'b0;
`endif
    outReady16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady16 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (inReady8 !== 1'b0 || outValid8 !== 1'b0 || s8 !== 8'h00 || cOut8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset8: inReady=%b outValid=%b s=%h cOut=%b, want 0 0 00 0",
               inReady8, outValid8, s8, cOut8);
    end
    checks++;
    if (inReady16 !== 1'b0 || outValid16 !== 1'b0 || s16 !== 16'h0000 || cOut16 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset16: inReady=%b outValid=%b s=%h cOut=%b, want 0 0 0000 0",
               inReady16, outValid16, s16, cOut16);
    end
`ifdef ADD_SUB_OVF_EN
    checks++;
    if (ovf8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ovf: got %b want 0", ovf8);
    end
`endif
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (inReady8 !== 1'b1 || inReady16 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b/%b want 1/1", inReady8, inReady16);
    end
  endtask

  task automatic test_directed8();
    logic [7:0] ta[7] = '{8'h35, 8'h0F, 8'hFF, 8'h7F, 8'h50, 8'h10, 8'h80};
    logic [7:0] tb[7] = '{8'h4A, 8'h01, 8'h01, 8'h01, 8'h20, 8'h20, 8'h01};
    logic       tu[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] ts[7] = '{8'h7F, 8'h10, 8'h00, 8'h80, 8'h30, 8'hF0, 8'h7F};
    logic       tc[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       tv[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic rdy, co, ov;
    logic [7:0] so;
    int lat;
    for (int i = 0; i < 7; i++) begin
      op8(ta[i], tb[i], tu[i], rdy, lat, so, co, ov);
      checks++;
      if (rdy !== 1'b1 || lat != 2) begin
        errors++;
        $display("[TB] FAIL directed%0d_timing: ready=%b latency=%0d want 1 2", i, rdy, lat);
      end
      checks++;
      if (so !== ts[i] || co !== tc[i]) begin
        errors++;
        $display("[TB] FAIL directed%0d_result: s=%h cOut=%b want s=%h cOut=%b",
                 i, so, co, ts[i], tc[i]);
      end
`ifdef ADD_SUB_OVF_EN
      checks++;
      if (ov !== tv[i]) begin
        errors++;
        $display("[TB] FAIL directed%0d_ovf: got %b want %b", i, ov, tv[i]);
      end
`else
      if (tv[i] === 1'bx) $display("[TB] unreachable");
`endif
    end
  endtask

  task automatic test_random8();
    logic [7:0] av, bv, so;
    logic subv, rdy, co, ov;
    logic [17:0] exp;
    int lat;
    for (int i = 0; i < 24; i++) begin
      av = 8'($urandom); bv = 8'($urandom); subv = 1'($urandom);
      exp = ref_model(8, {8'h00, av}, {8'h00, bv}, subv);
      op8(av, bv, subv, rdy, lat, so, co, ov);
      checks++;
      if (rdy !== 1'b1 || lat != 2 || so !== exp[7:0] || co !== exp[16]) begin
        errors++;
        $display("[TB] FAIL random8 %h %s %h: ready=%b lat=%0d s=%h c=%b want 1 2 %h %b",
                 av, subv ? "-" : "+", bv, rdy, lat, so, co, exp[7:0], exp[16]);
      end
`ifdef ADD_SUB_OVF_EN
      checks++;
      if (ov !== exp[17]) begin
        errors++;
        $display("[TB] FAIL random8_ovf %h %s %h: got %b want %b",
                 av, subv ? "-" : "+", bv, ov, exp[17]);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; inValid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid8 = 1'b0;
    lat = 0;
    while (outValid8 !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    a8 = 8'hAA; b8 = 8'h11; sub8 = 1'b1; inValid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (outValid8 !== 1'b1 || inReady8 !== 1'b0 || s8 !== 8'h46 || cOut8 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL backpressure_hold%0d: outValid=%b inReady=%b s=%h c=%b want 1 0 46 0",
                 i, outValid8, inReady8, s8, cOut8);
      end
    end
    outReady8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady8 = 1'b0;
    checks++;
    if (outValid8 !== 1'b0 || inReady8 !== 1'b1 || s8 !== 8'h46) begin
      errors++;
      $display("[TB] FAIL backpressure_release: outValid=%b inReady=%b s=%h want 0 1 46",
               outValid8, inReady8, s8);
    end
    @(posedge clk);
    @(negedge clk);
    inValid8 = 1'b0;
    checks++;
    if (inReady8 !== 1'b0 || s8 !== 8'h46) begin
      errors++;
      $display("[TB] FAIL backpressure_accept: inReady=%b s=%h want 0 46", inReady8, s8);
    end
    lat = 0;
    while (outValid8 !== 1'b1 && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    checks++;
    if (lat != 2 || s8 !== 8'h99 || cOut8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL backpressure_second: lat=%0d s=%h c=%b want 2 99 1", lat, s8, cOut8);
    end
    outReady8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady8 = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    logic rdy, co, ov;
    logic [7:0] so;
    int lat;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0; inValid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid8 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (outValid8 !== 1'b0 || s8 !== 8'h00 || cOut8 !== 1'b0 || inReady8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midcalc_reset: outValid=%b s=%h c=%b inReady=%b want 0 00 0 0",
               outValid8, s8, cOut8, inReady8);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (inReady8 !== 1'b1 || outValid8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midcalc_release: inReady=%b outValid=%b want 1 0", inReady8, outValid8);
    end
    op8(8'h01, 8'h01, 1'b0, rdy, lat, so, co, ov);
    checks++;
    if (rdy !== 1'b1 || lat != 2 || so !== 8'h02 || co !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midcalc_fresh: ready=%b lat=%0d s=%h c=%b want 1 2 02 0",
               rdy, lat, so, co);
    end
  endtask

  task automatic test_wide16();
    logic [15:0] av, bv, so;
    logic subv, rdy, co, ov;
    logic [17:0] exp;
    int lat;
    op16(16'hFFFF, 16'h0001, 1'b0, rdy, lat, so, co, ov);
    checks++;
    if (rdy !== 1'b1 || lat != 4 || so !== 16'h0000 || co !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wide16_ffff: ready=%b lat=%0d s=%h c=%b want 1 4 0000 1",
               rdy, lat, so, co);
    end
    for (int i = 0; i < 10; i++) begin
      av = 16'($urandom); bv = 16'($urandom); subv = 1'($urandom);
      exp = ref_model(16, av, bv, subv);
      op16(av, bv, subv, rdy, lat, so, co, ov);
      checks++;
      if (lat != 4 || so !== exp[15:0] || co !== exp[16]) begin
        errors++;
        $display("[TB] FAIL random16 %h %s %h: lat=%0d s=%h c=%b want 4 %h %b",
                 av, subv ? "-" : "+", bv, lat, so, co, exp[15:0], exp[16]);
      end
`ifdef ADD_SUB_OVF_EN
      checks++;
      if (ov !== exp[17]) begin
        errors++;
        $display("[TB] FAIL random16_ovf: got %b want %b", ov, exp[17]);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] expq[$];
    logic [17:0] exp;
    int sent, got, cyc, last_cyc;
    @(negedge clk);
    a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
    expq.push_back(ref_model(16, a16, b16, sub16));
    sent = 1; got = 0; cyc = 0; last_cyc = -1;
    inValid16 = 1'b1;
    outReady16 = 1'b1;
    while (got < 5 && cyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (outValid16 === 1'b1) begin
        exp = expq.pop_front();
        checks++;
        if (s16 !== exp[15:0] || cOut16 !== exp[16]) begin
          errors++;
          $display("[TB] FAIL b2b_result%0d: s=%h c=%b want %h %b", got, s16, cOut16,
                   exp[15:0], exp[16]);
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 6) begin
            errors++;
            $display("[TB] FAIL b2b_period%0d: got %0d cycles want 6", got, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
      if (inReady16 === 1'b1) begin
        if (sent < 5) begin
          a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
          expq.push_back(ref_model(16, a16, b16, sub16));
          sent++;
        end else begin
          inValid16 = 1'b0;
        end
      end
    end
    inValid16 = 1'b0;
    outReady16 = 1'b0;
    checks++;
    if (got != 5) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d results want 5", got);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    inValid8 = 1'b0; outReady8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
    inValid16 = 1'b0; outReady16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
    test_reset();
    test_directed8();
    test_random8();
    test_backpressure();
    test_reset_mid_calc();
    test_wide16();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
